pc_seq_ctrl: RTL

- Fetch/execute sequencer for the 8-bit program counter (`pc`).
- Requests an instruction word from instruction memory at the current PC and decodes it.
- Drives the PC's mode/offset command for exactly one cycle per instruction. Holds the PC with stop mode at all other times.
- Sits between `pc` and the instruction memory. Only this block commands `pc` in the core.

---
 rtl/pc_seq_ctrl_pkg.sv | 47 ++++
 rtl/pc_seq_ctrl_if.sv | 42 ++++
 rtl/pc_seq_ctrl_stack.sv | 85 ++++++++
 rtl/pc_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_ctrl_pkg
//
// Shared constants for the fetch/execute sequencer that drives the 8-bit
// program counter `pc`.
//   - pc_mode_*  : command encodings understood by pc.mode
//   - op_*       : instruction opcodes (instruction bits [11:8])
//   - seq_*      : sequencer FSM state encodings
//   - helpers    : opcode/immediate field extraction for a 12-bit word
//
// Optional feature macro (consumed by pc_seq_ctrl): PC_SEQ_CTRL_STACK_EN
// ----------------------------------------------------------------------------
package pc_seq_ctrl_pkg;

    // Commands for pc.mode
    localparam logic [2:0] pc_mode_stop   = 3'd0;  // hold current value
    localparam logic [2:0] pc_mode_normal = 3'd1;  // advance by one
    localparam logic [2:0] pc_mode_add    = 3'd2;  // pc + offset (mod 256)
    localparam logic [2:0] pc_mode_jump   = 3'd3;  // pc = offset

    // Instruction opcodes
    localparam logic [3:0] op_nop  = 4'd0;
    localparam logic [3:0] op_add  = 4'd1;
    localparam logic [3:0] op_jmp  = 4'd2;
    localparam logic [3:0] op_bz   = 4'd3;
    localparam logic [3:0] op_halt = 4'd4;
    localparam logic [3:0] op_call = 4'd5;
    localparam logic [3:0] op_ret  = 4'd6;

    // Sequencer states
    typedef enum logic [1:0] {
        seq_idle  = 2'd0,
        seq_fetch = 2'd1,
        seq_exec  = 2'd2,
        seq_halt  = 2'd3
    } seq_state_t;

    // Field extraction for the 12-bit instruction format
    function automatic logic [3:0] ir_opcode(input logic [11:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [7:0] ir_imm(input logic [11:0] ir);
        return ir[7:0];
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// pc_seq_ctrl_if
//
// Groups the sequencer's two buses: the instruction-memory fetch handshake
// and the command path to the program counter.
//   imem_req   sequencer -> memory  fetch request, address is pc_in
//   imem_ack   memory -> sequencer  instruction word valid this cycle
//   imem_data  memory -> sequencer  instruction word (IW bits)
//   pc_in      pc -> sequencer      current pc.pc_out
//   pc_mode    sequencer -> pc      pc.mode command (pc_mode_* constants)
//   pc_offset  sequencer -> pc      pc.offset command
//
// Modports: master = sequencer side, slave = memory/pc side.
// ----------------------------------------------------------------------------
interface pc_seq_ctrl_if #(
    parameter int IW = 12
);
    logic          imem_req;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic [7:0]    pc_in;
    logic [2:0]    pc_mode;
    logic [7:0]    pc_offset;

    modport master (
        output imem_req,
        output pc_mode,
        output pc_offset,
        input  imem_ack,
        input  imem_data,
        input  pc_in
    );

    modport slave (
        input  imem_req,
        input  pc_mode,
        input  pc_offset,
        output imem_ack,
        output imem_data,
        output pc_in
    );
endinterface

// File: rtl/pc_seq_ctrl_stack.sv
// ----------------------------------------------------------------------------
// pc_seq_stack
//
// Small LIFO holding return addresses for CALL/RET.
//   clk, reset  clock and asynchronous active-high reset (empties the stack)
//   push        write push_data on top (ignored when full)
//   pop         discard the top entry (ignored when empty or when pushing)
//   push_data   value to push (W bits)
//   top_data    current top entry, zero when empty
//   full/empty  occupancy flags
// Each entry is its own register so the top can be read combinationally in
// the same cycle the sequencer decides to jump to it.
// ----------------------------------------------------------------------------
module pc_seq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [DEPTH*W-1:0] entries_flat;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;

    always_comb begin
        count_next = count_reg;
        if (do_push) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Entry gi is written when it is the next free slot.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] value_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (do_push && (count_reg == CW'(gi))) begin
                    value_reg <= push_data;
                end
            end

            assign entries_flat[gi*W +: W] = value_reg;
        end
    endgenerate

    // Top of stack is the entry just below the occupancy count.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_reg == CW'(i + 1)) begin
                top_data = entries_flat[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// pc_seq_ctrl
//
// Fetch/execute sequencer for the 8-bit program counter. Fetches the word at
// pc_in, decodes it, and drives pc_mode/pc_offset for exactly one cycle per
// instruction; pc_mode is pc_mode_stop at every other time.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      level; leaves IDLE or HALT
//   zero_flag  BZ condition, looked at during EXEC
//   bus        pc_seq_ctrl_if.master (imem handshake + pc command)
//   halted     high while in HALT
//   err        sticky: illegal opcode or stack fault
//   retired    count of executed (non-HALT, legal) instructions, wraps
//
// Optional feature: define PC_SEQ_CTRL_STACK_EN to enable CALL/RET with a
// STACK_DEPTH-entry return-address stack. Without it, opcodes 5/6 are illegal.
// ----------------------------------------------------------------------------
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int IW          = 12,
    parameter int CNT_W       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              zero_flag,
    pc_seq_ctrl_if.master     bus,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [IW-1:0]    ir_reg;
    logic [IW-1:0]    ir_next;
    logic             err_reg;
    logic             err_next;
    logic [CNT_W-1:0] retired_reg;
    logic [CNT_W-1:0] retired_next;

    logic             req_c;
    logic [2:0]       mode_c;
    logic [7:0]       offset_c;
    logic             retire_c;
    logic             fault_c;

    logic [3:0]       opcode;
    logic [7:0]       imm;

    assign opcode = ir_opcode(ir_reg);
    assign imm    = ir_imm(ir_reg);

`ifdef PC_SEQ_CTRL_STACK_EN
    logic       stk_push;
    logic       stk_pop;
    logic       stk_full;
    logic       stk_empty;
    logic [7:0] stk_top;

    // Return address is the instruction after the CALL, modulo 256.
    pc_seq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (8)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (bus.pc_in + 8'd1),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`else
    // pc_in and STACK_DEPTH only matter to the return-address stack.
    wire unused_cfg = ^{STACK_DEPTH, bus.pc_in};
`endif

    // State register. Everything the outputs depend on resets asynchronously,
    // so a reset mid-fetch drops imem_req without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= seq_idle;
            ir_reg      <= '0;
            err_reg     <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ir_reg      <= ir_next;
            err_reg     <= err_next;
            retired_reg <= retired_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next   = state_reg;
        ir_next      = ir_reg;
        err_next     = err_reg;
        retired_next = retired_reg;
        req_c        = 1'b0;
        mode_c       = pc_mode_stop;
        offset_c     = 8'd0;
        retire_c     = 1'b0;
        fault_c      = 1'b0;
`ifdef PC_SEQ_CTRL_STACK_EN
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
`endif

        case (state_reg)
            seq_idle: begin
                if (start) begin
                    state_next = seq_fetch;
                end
            end

            seq_fetch: begin
                // Request stays up until the memory answers.
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_next    = bus.imem_data;
                    state_next = seq_exec;
                end
            end

            seq_exec: begin
                state_next = seq_fetch;
                retire_c   = 1'b1;
                case (opcode)
                    op_nop: begin
                        mode_c   = pc_mode_normal;
                        offset_c = 8'd1;
                    end
                    op_add: begin
                        mode_c   = pc_mode_add;
                        offset_c = imm;
                    end
                    op_jmp: begin
                        mode_c   = pc_mode_jump;
                        offset_c = imm;
                    end
                    op_bz: begin
                        if (zero_flag) begin
                            mode_c   = pc_mode_add;
                            offset_c = imm;
                        end else begin
                            mode_c   = pc_mode_normal;
                            offset_c = 8'd1;
                        end
                    end
                    op_halt: begin
                        state_next = seq_halt;
                        retire_c   = 1'b0;
                    end
`ifdef PC_SEQ_CTRL_STACK_EN
                    op_call: begin
                        if (stk_full) begin
                            fault_c = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                            mode_c   = pc_mode_jump;
                            offset_c = imm;
                        end
                    end
                    op_ret: begin
                        if (stk_empty) begin
                            fault_c = 1'b1;
                        end else begin
                            stk_pop  = 1'b1;
                            mode_c   = pc_mode_jump;
                            offset_c = stk_top;
                        end
                    end
`endif
                    default: begin
                        fault_c = 1'b1;
                    end
                endcase

                // A fault leaves pc_mode at stop and the stack untouched.
                if (fault_c) begin
                    err_next   = 1'b1;
                    state_next = seq_halt;
                    retire_c   = 1'b0;
                end

                if (retire_c) begin
                    retired_next = retired_reg + cnt_one;
                end
            end

            seq_halt: begin
                // err is deliberately kept across a restart.
                if (start) begin
                    state_next = seq_fetch;
                end
            end

            default: begin
                state_next = seq_idle;
            end
        endcase
    end

    assign bus.imem_req  = req_c;
    assign bus.pc_mode   = mode_c;
    assign bus.pc_offset = offset_c;
    assign halted        = (state_reg == seq_halt);
    assign err           = err_reg;
    assign retired       = retired_reg;

endmodule
